// File: rtl/infer_sequencer.sv
// infer_sequencer
//   Sequences one handwritten-digit inference: optionally clears the 56x56
//   drawing canvas, copies a 2:1 decimated 28x28 image into the network's
//   image memory, releases the network from reset and waits for its answer
//   (or a timeout).
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   start, clear   inference / canvas-clear requests (clear wins)
//   canvas_addr    canvas address: read during COPY, write (data 0) during CLEAR
//   canvas_data    canvas read data for the canvas_addr currently presented
//   canvas_we      canvas write enable (CLEAR only)
//   img_we/img_addr/img_data   image memory write port (COPY only)
//   nn_rst         network engine reset, released only in RUN
//   digit, digit_valid         network result and strobe
//   result, result_valid       latched digit
//   busy           any state other than IDLE
//   err            sticky: timeout or digit > 9
//
// States
//   IDLE  | waiting for start / clear
//   CLEAR | zeroing the canvas, one address per cycle
//   COPY  | reading every second pixel of every second row into the image
//   RUN   | network running, waiting for digit_valid or timeout
//
// canvas_addr leaves this block straight from a flop, so the canvas memory's
// output for that address is captured into img_data at the end of the same
// cycle; the image write therefore lands exactly one cycle after its read
// address, and COPY needs one extra drain cycle for the last pixel.

module infer_sequencer #(
    parameter int CANVAS_W = 56,
    parameter int IMG_W    = 28,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    output logic [11:0] canvas_addr,
    input  logic        canvas_data,
    output logic        canvas_we,
    output logic        img_we,
    output logic [9:0]  img_addr,
    output logic        img_data,
    output logic        nn_rst,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    output logic [3:0]  result,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);

    localparam int               RUN_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(TIMEOUT - 1);
    localparam logic [11:0]      CANVAS_LAST = 12'(CANVAS_W * CANVAS_W - 1);
    localparam logic [4:0]       IDX_LAST    = 5'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COPY  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       row, row_nxt;
    logic [4:0]       col, col_nxt;
    logic             drain, drain_nxt;
    logic [RUN_W-1:0] run_cnt, run_cnt_nxt;

    logic [11:0] canvas_addr_nxt;
    logic        canvas_we_nxt;
    logic        img_we_nxt;
    logic [9:0]  img_addr_nxt;
    logic        img_data_nxt;
    logic        nn_rst_nxt;
    logic [3:0]  result_nxt;
    logic        result_valid_nxt;
    logic        busy_nxt;
    logic        err_nxt;

    function automatic logic [11:0] canvas_index(input logic [4:0] r, input logic [4:0] c);
        return 12'(2 * CANVAS_W * int'(r) + 2 * int'(c));
    endfunction

    function automatic logic [9:0] img_index(input logic [4:0] r, input logic [4:0] c);
        return 10'(IMG_W * int'(r) + int'(c));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            drain        <= 1'b0;
            run_cnt      <= '0;
            canvas_addr  <= '0;
            canvas_we    <= 1'b0;
            img_we       <= 1'b0;
            img_addr     <= '0;
            img_data     <= 1'b0;
            nn_rst       <= 1'b1;
            result       <= 4'hF;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            row          <= row_nxt;
            col          <= col_nxt;
            drain        <= drain_nxt;
            run_cnt      <= run_cnt_nxt;
            canvas_addr  <= canvas_addr_nxt;
            canvas_we    <= canvas_we_nxt;
            img_we       <= img_we_nxt;
            img_addr     <= img_addr_nxt;
            img_data     <= img_data_nxt;
            nn_rst       <= nn_rst_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        row_nxt          = row;
        col_nxt          = col;
        drain_nxt        = drain;
        run_cnt_nxt      = run_cnt;
        canvas_addr_nxt  = canvas_addr;
        canvas_we_nxt    = canvas_we;
        img_we_nxt       = 1'b0;
        img_addr_nxt     = img_addr;
        img_data_nxt     = img_data;
        nn_rst_nxt       = nn_rst;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        busy_nxt         = busy;
        err_nxt          = err;

        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt        = CLEAR;
                    canvas_addr_nxt  = '0;
                    canvas_we_nxt    = 1'b1;
                    busy_nxt         = 1'b1;
                    result_valid_nxt = 1'b0;
                    err_nxt          = 1'b0;
                end else if (start) begin
                    state_nxt        = COPY;
                    row_nxt          = '0;
                    col_nxt          = '0;
                    drain_nxt        = 1'b0;
                    canvas_addr_nxt  = '0;
                    busy_nxt         = 1'b1;
                    result_valid_nxt = 1'b0;
                    err_nxt          = 1'b0;
                end
            end

            CLEAR: begin
                if (canvas_addr == CANVAS_LAST) begin
                    state_nxt       = IDLE;
                    canvas_addr_nxt = '0;
                    canvas_we_nxt   = 1'b0;
                    busy_nxt        = 1'b0;
                end else begin
                    canvas_addr_nxt = canvas_addr + 12'd1;
                end
            end

            COPY: begin
                if (clear) begin
                    state_nxt       = CLEAR;
                    canvas_addr_nxt = '0;
                    canvas_we_nxt   = 1'b1;
                    nn_rst_nxt      = 1'b1;
                end else if (drain) begin
                    state_nxt       = RUN;
                    canvas_addr_nxt = '0;
                    run_cnt_nxt     = '0;
                    nn_rst_nxt      = 1'b0;
                end else begin
                    img_we_nxt   = 1'b1;
                    img_addr_nxt = img_index(row, col);
                    img_data_nxt = canvas_data;
                    if (col == IDX_LAST) begin
                        col_nxt = '0;
                        if (row == IDX_LAST) begin
                            drain_nxt = 1'b1;
                        end else begin
                            row_nxt = row + 5'd1;
                        end
                    end else begin
                        col_nxt = col + 5'd1;
                    end
                    canvas_addr_nxt = drain_nxt ? 12'd0 : canvas_index(row_nxt, col_nxt);
                end
            end

            RUN: begin
                if (clear) begin
                    state_nxt       = CLEAR;
                    canvas_addr_nxt = '0;
                    canvas_we_nxt   = 1'b1;
                    nn_rst_nxt      = 1'b1;
                end else if (digit_valid) begin
                    state_nxt        = IDLE;
                    result_nxt       = digit;
                    result_valid_nxt = 1'b1;
                    err_nxt          = (digit > 4'd9);
                    nn_rst_nxt       = 1'b1;
                    busy_nxt         = 1'b0;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt  = IDLE;
                    err_nxt    = 1'b1;
                    nn_rst_nxt = 1'b1;
                    busy_nxt   = 1'b0;
                end else begin
                    run_cnt_nxt = run_cnt + RUN_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_infer_sequencer.sv
`timescale 1ns/1ps
module tb_infer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear, digit_valid;
    logic [3:0]  digit;

    logic [11:0] canvas_addr;
    logic        canvas_data, canvas_we, img_we, img_data, nn_rst;
    logic [9:0]  img_addr;
    logic [3:0]  result;
    logic        result_valid, busy, err;

    logic [11:0] canvas_addr_t;
    logic        canvas_data_t, canvas_we_t, img_we_t, img_data_t, nn_rst_t;
    logic [9:0]  img_addr_t;
    logic [3:0]  result_t;
    logic        result_valid_t, busy_t, err_t;

    logic mem [0:4095];

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    infer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .canvas_addr(canvas_addr), .canvas_data(canvas_data), .canvas_we(canvas_we),
        .img_we(img_we), .img_addr(img_addr), .img_data(img_data), .nn_rst(nn_rst),
        .digit(digit), .digit_valid(digit_valid), .result(result),
        .result_valid(result_valid), .busy(busy), .err(err)
    );

    infer_sequencer #(.TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .canvas_addr(canvas_addr_t), .canvas_data(canvas_data_t), .canvas_we(canvas_we_t),
        .img_we(img_we_t), .img_addr(img_addr_t), .img_data(img_data_t), .nn_rst(nn_rst_t),
        .digit(digit), .digit_valid(digit_valid), .result(result_t),
        .result_valid(result_valid_t), .busy(busy_t), .err(err_t)
    );

    // canvas memory: address flop is in the DUT, read data follows it directly
    assign canvas_data   = mem[canvas_addr];
    assign canvas_data_t = mem[canvas_addr_t];

    always @(posedge clk) begin
        if (canvas_we) mem[canvas_addr] = 1'b0;
    end

    always @(negedge clk) begin
        if ((canvas_we && img_we) || (canvas_we_t && img_we_t)) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] exp_caddr(input int k);
        int r;
        int c;
        r = k / 28;
        c = k % 28;
        return 12'(2 * r * 56 + 2 * c);
    endfunction

    task automatic fill_mem(input int pat);
        for (int a = 0; a < 4096; a++) begin
            if (pat == 0) mem[a] = 1'(((a / 56) + (a % 56)) % 2);
            else          mem[a] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (nn_rst === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clear = 1'b0; digit = 4'd0; digit_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({canvas_we, img_we, img_data, nn_rst, result_valid, busy, err} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0001000", {canvas_we, img_we, img_data, nn_rst, result_valid, busy, err});
        end
        checks++;
        if (canvas_addr !== 12'd0 || img_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr: canvas_addr=%0d img_addr=%0d want 0 0", canvas_addr, img_addr);
        end
        checks++;
        if (result !== 4'hF) begin
            errors++;
            $display("FAIL reset_result: got %h want f", result);
        end
    endtask

    task automatic test_copy_run(input int pat, input logic [3:0] dig, input int wait_cycles);
        int  bad = 0;
        int  nwr = 0;
        int  runbad = 0;
        fill_mem(pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 785; k++) begin
            if (nn_rst !== 1'b1 || busy !== 1'b1 || canvas_we !== 1'b0) bad++;
            if (k < 784 && canvas_addr !== exp_caddr(k)) bad++;
            if (k == 0) begin
                if (img_we !== 1'b0) bad++;
            end else begin
                if (img_we === 1'b1) nwr++;
                if (img_we !== 1'b1 || img_addr !== 10'(k - 1) || img_data !== mem[exp_caddr(k - 1)]) bad++;
            end
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL copy_stream pat%0d: %0d bad cycles, want 0", pat, bad);
        end
        checks++;
        if (nwr !== 784) begin
            errors++;
            $display("FAIL copy_writes pat%0d: got %0d want 784", pat, nwr);
        end
        checks++;
        if (nn_rst !== 1'b0 || busy !== 1'b1 || img_we !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: nn_rst=%b busy=%b img_we=%b want 0 1 0", nn_rst, busy, img_we);
        end
        repeat (wait_cycles) begin
            tick();
            if (nn_rst !== 1'b0) runbad++;
        end
        checks++;
        if (runbad !== 0) begin
            errors++;
            $display("FAIL run_hold: left RUN early in %0d cycles, want 0", runbad);
        end
        digit = dig;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        checks++;
        if (result !== dig || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_result: result=%0d valid=%b want %0d 1", result, result_valid, dig);
        end
        checks++;
        if (err !== (dig > 4'd9) || busy !== 1'b0 || nn_rst !== 1'b1) begin
            errors++;
            $display("FAIL run_done: err=%b busy=%b nn_rst=%b want %b 0 1", err, busy, nn_rst, (dig > 4'd9));
        end
    endtask

    task automatic test_start_and_clear();
        int bad = 0;
        int nz = 0;
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        for (int k = 0; k < 3136; k++) begin
            if (canvas_we !== 1'b1 || canvas_addr !== 12'(k) || img_we !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear_stream: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (canvas_we !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: canvas_we=%b busy=%b result_valid=%b want 0 0 0", canvas_we, busy, result_valid);
        end
        for (int a = 0; a < 3136; a++) if (mem[a] !== 1'b0) nz++;
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL clear_mem: %0d nonzero pixels, want 0", nz);
        end
    endtask

    task automatic test_clear_abort_copy();
        bit ok;
        fill_mem(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        checks++;
        if (img_we !== 1'b1 || img_addr !== 10'd99) begin
            errors++;
            $display("FAIL abort_copy_pre: img_we=%b img_addr=%0d want 1 99", img_we, img_addr);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (img_we !== 1'b0 || canvas_we !== 1'b1 || canvas_addr !== 12'd0 || nn_rst !== 1'b1) begin
            errors++;
            $display("FAIL abort_copy: img_we=%b canvas_we=%b canvas_addr=%0d nn_rst=%b want 0 1 0 1", img_we, canvas_we, canvas_addr, nn_rst);
        end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL abort_copy_idle: timed out, got %b want 1", ok);
        end
    endtask

    task automatic test_clear_abort_run();
        bit ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL abort_run_enter: timed out, got %b want 1", ok);
        end
        repeat (20) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (nn_rst !== 1'b1 || canvas_we !== 1'b1 || canvas_addr !== 12'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_run: nn_rst=%b canvas_we=%b canvas_addr=%0d busy=%b want 1 1 0 1", nn_rst, canvas_we, canvas_addr, busy);
        end
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL abort_run_idle: timed out, got %b want 1", ok);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        bit seen = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (nn_rst_t === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        ok = seen;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL timeout_enter: timed out, got %b want 1", ok);
        end
        while (nn_rst_t === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_len: RUN lasted %0d cycles, want 16", n);
        end
        checks++;
        if (err_t !== 1'b1 || result_valid_t !== 1'b0 || busy_t !== 1'b0 || result_t !== 4'hF) begin
            errors++;
            $display("FAIL timeout_flags: err=%b valid=%b busy=%b result=%h want 1 0 0 f", err_t, result_valid_t, busy_t, result_t);
        end
        checks++;
        if (nn_rst !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL long_timeout_run: nn_rst=%b err=%b want 0 0", nn_rst, err);
        end
        start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        checks++;
        if (nn_rst !== 1'b0 || busy_t !== 1'b1) begin
            errors++;
            $display("FAIL start_held: run nn_rst=%b idle-retrigger busy=%b want 0 1", nn_rst, busy_t);
        end
        digit = 4'd12;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || result !== 4'hC || result_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL digit_range: err=%b result=%h valid=%b busy=%b want 1 c 1 0", err, result, result_valid, busy);
        end
        digit = 4'd5;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        tick();
        checks++;
        if (result !== 4'hC || result_valid !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL digit_idle_ignored: result=%h valid=%b err=%b busy=%b want c 1 1 0", result, result_valid, err, busy);
        end
    endtask

    task automatic test_rst_mid_run();
        bit ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_run_enter: timed out, got %b want 1", ok);
        end
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({canvas_we, img_we, img_data, nn_rst, result_valid, busy, err} !== 7'b0001000 ||
            canvas_addr !== 12'd0 || img_addr !== 10'd0 || result !== 4'hF) begin
            errors++;
            $display("FAIL rst_mid_run: flags=%b canvas_addr=%0d img_addr=%0d result=%h want 0001000 0 0 f",
                     {canvas_we, img_we, img_data, nn_rst, result_valid, busy, err}, canvas_addr, img_addr, result);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        checks++;
        if (canvas_we !== 1'b1 || canvas_addr !== 12'd10) begin
            errors++;
            $display("FAIL clear_progress: canvas_we=%b canvas_addr=%0d want 1 10", canvas_we, canvas_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (canvas_we !== 1'b0 || busy !== 1'b0 || canvas_addr !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: canvas_we=%b busy=%b canvas_addr=%0d want 0 0 0", canvas_we, busy, canvas_addr);
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL we_overlap: %0d cycles with both enables, want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_copy_run(0, 4'd7, 500);
        test_copy_run(1, 4'd3, 5);
        test_start_and_clear();
        test_clear_abort_copy();
        test_clear_abort_run();
        test_timeout();
        test_rst_mid_run();
        test_copy_run(1, 4'd2, 40);
        test_no_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
